// File: rtl/prm_pkg.sv
// Shared definitions for the PRM motion back-end: position width, signed
// position type and the driver state encoding.
package prm_pkg;

  localparam int POS_W = 32;

  typedef logic signed [POS_W-1:0] pos_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: latched (clamped) target, tracked position and step/direction
// generation. The clamp bounds come from the top; full range means no clamping.
module stepper_axis
  import prm_pkg::*;
#(
  parameter pos_t LIMIT_LO = pos_t'(32'h8000_0000),
  parameter pos_t LIMIT_HI = pos_t'(32'h7FFF_FFFF)
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic load,
  input  pos_t aim,
  input  logic slotStart,
  input  logic pulseEnd,
  output pos_t position,
  output logic stepOut,
  output logic dirOut,
  output logic atTarget
);

  pos_t target;

  function automatic pos_t clampPos(input pos_t v);
    if (v < LIMIT_LO) return LIMIT_LO;
    if (v > LIMIT_HI) return LIMIT_HI;
    return v;
  endfunction

  assign atTarget = (position == target);

  // stepOut doubles as the "active this slot" flag for the position update
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      target   <= '0;
      position <= '0;
      stepOut  <= 1'b0;
      dirOut   <= 1'b0;
    end else begin
      if (load) target <= clampPos(aim);
      if (slotStart && !atTarget) begin
        dirOut  <= (target > position);
        stepOut <= 1'b1;
      end else if (pulseEnd && stepOut) begin
        stepOut  <= 1'b0;
        position <= dirOut ? position + 1 : position - 1;
      end
    end
  end

endmodule

// File: rtl/stepper_driver.sv
// Lock-step multi-axis stepper driver: takes an aim pose, pulses every axis toward
// it on a shared slot timer. Define STEPPER_SOFT_LIMIT_EN to clamp targets to [POS_MIN, POS_MAX].
module stepper_driver
  import prm_pkg::*;
#(
  parameter int   STEPPERS_NUM = 6,
  parameter int   STEP_PERIOD  = 1000,
  parameter int   PULSE_HIGH   = 100,
  parameter pos_t POS_MIN      = pos_t'(32'h8000_0000),
  parameter pos_t POS_MAX      = pos_t'(32'h7FFF_FFFF)
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic [POS_W*STEPPERS_NUM-1:0] AimPosition,
  input  logic                          aimValid,
  output logic                          aimReady,
  output logic [POS_W*STEPPERS_NUM-1:0] stepperPosition,
  output logic [STEPPERS_NUM-1:0]       stepOut,
  output logic [STEPPERS_NUM-1:0]       dirOut,
  output logic                          moveDone
);

  localparam int CNT_W = $clog2(STEP_PERIOD);

`ifdef STEPPER_SOFT_LIMIT_EN
  localparam pos_t LimitLo = POS_MIN;
  localparam pos_t LimitHi = POS_MAX;
`else
  localparam pos_t LimitLo = pos_t'(32'h8000_0000);
  localparam pos_t LimitHi = pos_t'(32'h7FFF_FFFF);
`endif

  if (PULSE_HIGH < 1) begin : gBadPulseHigh
    $error("PULSE_HIGH must be at least 1");
  end
  if (STEP_PERIOD < PULSE_HIGH + 2) begin : gBadStepPeriod
    $error("STEP_PERIOD must be at least PULSE_HIGH+2");
  end
  if (POS_MIN > POS_MAX) begin : gBadLimits
    $error("POS_MIN must not exceed POS_MAX");
  end

  state_t                  state;
  state_t                  stateNext;
  logic [CNT_W-1:0]        count;
  logic [STEPPERS_NUM-1:0] atTarget;
  logic                    running;
  logic                    accept;
  logic                    slotStart;
  logic                    pulseEnd;
  logic                    slotLast;
  logic                    allDone;

  assign running   = (state == RUN);
  assign accept    = aimValid && aimReady;
  assign slotStart = running && (count == '0);
  assign pulseEnd  = running && (count == CNT_W'(PULSE_HIGH));
  assign slotLast  = running && (count == CNT_W'(STEP_PERIOD - 1));
  assign allDone   = &atTarget;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    aimReady  = 1'b0;
    case (state)
      IDLE: begin
        aimReady = 1'b1;
        if (aimValid) stateNext = RUN;
      end
      RUN: if (slotLast && allDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Done is judged at the slot's last count, after this slot's position updates
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      count    <= '0;
      moveDone <= 1'b0;
    end else begin
      moveDone <= slotLast && allDone;
      if (accept || slotLast) count <= '0;
      else if (running)       count <= count + 1'b1;
    end
  end

  for (genvar i = 0; i < STEPPERS_NUM; i++) begin : gAxis
    stepper_axis #(
      .LIMIT_LO(LimitLo),
      .LIMIT_HI(LimitHi)
    ) uAxis (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .load     (accept),
      .aim      (AimPosition[POS_W*i +: POS_W]),
      .slotStart(slotStart),
      .pulseEnd (pulseEnd),
      .position (stepperPosition[POS_W*i +: POS_W]),
      .stepOut  (stepOut[i]),
      .dirOut   (dirOut[i]),
      .atTarget (atTarget[i])
    );
  end

endmodule

// File: tb/tb_stepper_driver.sv
// Directed scoreboard bench for stepper_driver (STEP_PERIOD=10, PULSE_HIGH=3);
// the clamp case runs only when STEPPER_SOFT_LIMIT_EN is defined.
module tb_stepper_driver;
  import prm_pkg::*;

  localparam int     N          = 6;
  localparam int     P          = 10;
  localparam int     PH         = 3;
  localparam longint TB_POS_MAX = 4;

  typedef logic [N-1:0][31:0] pose_t;
  typedef struct packed {
    pose_t       pos;
    pose_t       pulses;
    logic [N-1:0] dir;
    logic [31:0] runLen;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RST_n;
  pose_t          AimPosition;
  logic           aimValid;
  logic           aimReady;
  logic [32*N-1:0] stepperPosition;
  logic [N-1:0]   stepOut;
  logic [N-1:0]   dirOut;
  logic           moveDone;

  stepper_driver #(
    .STEPPERS_NUM(N),
    .STEP_PERIOD (P),
    .PULSE_HIGH  (PH),
    .POS_MIN     (32'sh8000_0000),
    .POS_MAX     (32'sd4)
  ) dut (
    .CLK            (CLK),
    .RST_n          (RST_n),
    .AimPosition    (AimPosition),
    .aimValid       (aimValid),
    .aimReady       (aimReady),
    .stepperPosition(stepperPosition),
    .stepOut        (stepOut),
    .dirOut         (dirOut),
    .moveDone       (moveDone)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int     checks   = 0;
  int     failures = 0;
  exp_t   q[$];
  longint modelPos[N];
  bit     monEn = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  function automatic logic [31:0] posOf(input int i);
    return stepperPosition[32*i +: 32];
  endfunction

  // Reference model: distance, direction and slot count from the previous pose
  function automatic void pushExp(input pose_t p);
    exp_t   e;
    longint a;
    longint d;
    longint maxD;
    maxD = 0;
    e = '0;
    for (int i = 0; i < N; i++) begin
      a = longint'($signed(p[i]));
`ifdef STEPPER_SOFT_LIMIT_EN
      if (a > TB_POS_MAX) a = TB_POS_MAX;
`endif
      d = a - modelPos[i];
      e.dir[i] = (d > 0);
      if (d < 0) d = -d;
      e.pulses[i] = d[31:0];
      if (d > maxD) maxD = d;
      e.pos[i] = a[31:0];
      modelPos[i] = a;
    end
    e.runLen = 32'((maxD == 0 ? 1 : maxD) * P);
    q.push_back(e);
  endfunction

  logic [N-1:0]  prevStep  = '0;
  logic          prevReady = 1'b1;
  logic          prevDone  = 1'b0;
  int            riseCyc[N];
  logic [31:0]   risePos[N];
  int            pulseCnt[N];
  int            runStart  = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (monEn) begin
      if (prevReady && !aimReady) begin
        runStart <= cyc;
        for (int i = 0; i < N; i++) pulseCnt[i] <= 0;
      end
      if (prevDone) chk("moveDoneWidth", 32'(moveDone), 0);
      for (int i = 0; i < N; i++) begin
        if (stepOut[i] && !prevStep[i]) begin
          riseCyc[i]  <= cyc;
          risePos[i]  <= posOf(i);
          pulseCnt[i] <= pulseCnt[i] + 1;
          chk("sbHasMoveAtRise", 32'(q.size() > 0), 1);
          if (q.size() > 0) chk($sformatf("dirAtRise%0d", i), 32'(dirOut[i]), 32'(q[0].dir[i]));
          chk($sformatf("risePhase%0d", i), (cyc - runStart) % P, 1);
        end
        if (!stepOut[i] && prevStep[i]) begin
          chk($sformatf("pulseWidth%0d", i), cyc - riseCyc[i], PH);
          if (q.size() > 0)
            chk($sformatf("posAtFall%0d", i), posOf(i),
                q[0].dir[i] ? risePos[i] + 32'd1 : risePos[i] - 32'd1);
        end
      end
      if (moveDone) begin
        chk("sbHasMoveAtDone", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("runLen", cyc - runStart, e.runLen);
          chk("readyAtDone", 32'(aimReady), 1);
          for (int i = 0; i < N; i++) begin
            chk($sformatf("finalPos%0d", i), posOf(i), e.pos[i]);
            chk($sformatf("pulseCount%0d", i), pulseCnt[i], e.pulses[i]);
          end
        end
      end
    end
    prevStep  <= stepOut;
    prevReady <= aimReady;
    prevDone  <= moveDone;
  end

  task automatic sendAim(input pose_t p);
    pushExp(p);
    @(negedge CLK);
    AimPosition = p;
    aimValid    = 1'b1;
    @(negedge CLK);
    aimValid    = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (moveDone !== 1'b1 && n < budget);
    chk("doneWithinBudget", 32'(moveDone), 1);
  endtask

  initial begin
    pose_t p;
    pose_t pA;
    pose_t pB;
    int    n;
    RST_n       = 1'b0;
    aimValid    = 1'b0;
    AimPosition = '0;
    for (int i = 0; i < N; i++) modelPos[i] = 0;
    repeat (2) @(negedge CLK);
    chk("rstReady", 32'(aimReady), 1);
    chk("rstPosZero", 32'(stepperPosition == '0), 1);
    chk("rstStep", 32'(stepOut), 0);
    chk("rstDir", 32'(dirOut), 0);
    chk("rstDone", 32'(moveDone), 0);
    RST_n = 1'b1;
    monEn = 1'b1;
    @(negedge CLK);

    p = '0;
    p[0] = 32'd5;
    sendAim(p);
    waitDone(200);

    p[1] = -32'sd3;
    p[2] = 32'd2;
    sendAim(p);
    waitDone(200);

    sendAim(p);
    waitDone(50);

    // Held aimValid with a changed pose while the first move runs
    pA = p;
    pA[3] = 32'd2;
    pushExp(pA);
    @(negedge CLK);
    AimPosition = pA;
    aimValid    = 1'b1;
    @(negedge CLK);
    pB = pA;
    pB[3] = -32'sd1;
    pB[4] = 32'd1;
    AimPosition = pB;
    pushExp(pB);
    repeat (5) @(negedge CLK);
    chk("readyLowInRun", 32'(aimReady), 0);
    waitDone(100);
    @(negedge CLK);
    aimValid = 1'b0;
    chk("secondPoseTaken", 32'(aimReady), 0);
    waitDone(100);

    // Asynchronous reset in the middle of a pulse
    p = pB;
    p[5] = 32'd4;
    sendAim(p);
    n = 0;
    while (stepOut[5] !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("pulseBeforeReset", 32'(stepOut[5]), 1);
    monEn = 1'b0;
    #2 RST_n = 1'b0;
    #1;
    chk("asyncRstStep", 32'(stepOut), 0);
    chk("asyncRstPosZero", 32'(stepperPosition == '0), 1);
    chk("asyncRstReady", 32'(aimReady), 1);
    chk("asyncRstDir", 32'(dirOut), 0);
    q.delete();
    for (int i = 0; i < N; i++) modelPos[i] = 0;
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);
    monEn = 1'b1;

    p = '0;
    p[0] = -32'sd2;
    sendAim(p);
    waitDone(100);

`ifdef STEPPER_SOFT_LIMIT_EN
    p = '0;
    p[1] = 32'd7;
    sendAim(p);
    waitDone(200);
`endif

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stepper_driver.md
# stepper_driver

Motion back-end for the PRM planner. Accepts an aim pose (one signed 32-bit target per stepper), emits step/direction pulses on every axis until the tracked positions equal the targets, and reports the live position vector. That vector is the planner's `stepperPosition` input, closing the planner–actuator loop. All axes step in lock-step on a shared period timer; the next aim pose is taken only after the current move completes.

## Interface
- `STEPPERS_NUM`, 6, number of axes.
- `STEP_PERIOD`, 1000, clock cycles per step slot; must be ≥ `PULSE_HIGH`+2.
- `PULSE_HIGH`, 100, cycles that `stepOut` is held high per pulse; must be ≥ 1.
- `POS_MIN`, -2147483648, lower soft limit (signed); used only with the macro.
- `POS_MAX`, 2147483647, upper soft limit (signed); used only with the macro.

- `CLK`  in  1  clock; single clock domain.
- `RST_n`  in  1  asynchronous, active-low reset.
- `AimPosition`  in  32*STEPPERS_NUM  target per axis, signed two's complement; axis i at bits [32i+31:32i].
- `aimValid`  in  1  `AimPosition` is valid.
- `aimReady`  out  1  block will accept an aim.
- `stepperPosition`  out  32*STEPPERS_NUM  current tracked position per axis, signed; same packing.
- `stepOut`  out  STEPPERS_NUM  step pulse per axis.
- `dirOut`  out  STEPPERS_NUM  1 = increment, 0 = decrement.
- `moveDone`  out  1  one-cycle pulse when a move completes.

## Operation
- Reset values: state IDLE, `aimReady`=1, `stepperPosition`=0, targets=0, `stepOut`=0, `dirOut`=0, `moveDone`=0, period counter=0.
- States: IDLE, RUN.
- IDLE: `aimReady`=1. On `aimValid && aimReady`, latch all targets, clear the counter, go to RUN.
- RUN: `aimReady`=0. `aimValid` is ignored and never queued. The counter runs 0..STEP_PERIOD-1 and then wraps.
  - At count 0, each axis with position ≠ target is active. Its `dirOut` is set to (target > position), signed compare, and `stepOut` is set to 1. Inactive axes keep `dirOut` and hold `stepOut` at 0.
  - At count PULSE_HIGH, each active axis clears `stepOut` and updates its position by +1 or -1.
  - At count STEP_PERIOD-1, if every position equals its target, go to IDLE and pulse `moveDone`. Otherwise continue with the next slot.
- Each axis moves at most one step per slot. Axes with shorter distances finish early and then idle while the others complete.
- Position arithmetic is 32-bit signed. Wrap-around cannot occur because targets are in range and motion is toward the target.
- Reset asserted mid-move aborts immediately: all outputs return to their reset values, and position is lost (reset to 0).

## Timing
- Aim accepted at the edge ending cycle T. RUN begins at T+1 with count 0.
- `dirOut` and `stepOut` first become visible at T+2, so `dirOut` is valid together with the rising edge of `stepOut`. `stepOut` stays high for exactly PULSE_HIGH cycles.
- The position change becomes visible in the cycle in which `stepOut` falls.
- Move of max axis distance N ≥ 1: RUN lasts N×STEP_PERIOD cycles. With N = 0: RUN lasts STEP_PERIOD cycles and no pulses are issued.
- `moveDone` and `aimReady` rise in the same cycle, the first cycle of IDLE. The next aim can be accepted in that cycle.

## Configuration
- `STEPPER_SOFT_LIMIT_EN` defined: each aim component is clamped to [POS_MIN, POS_MAX] when latched. `stepperPosition` therefore never leaves that range.
- `STEPPER_SOFT_LIMIT_EN` undefined: targets are latched unmodified, and POS_MIN/POS_MAX are unused.

## Structure
- Shared package `prm_pkg`: the 32-bit position width constant, the signed position typedef, and the state enum.
- One sub-module, `stepper_axis`: per-axis target/position registers, compare, direction, step and clamp logic. It is instantiated STEPPERS_NUM times by generate.
- Top level keeps the FSM, the shared period counter, and the all-axes-done reduction.

## Test plan
Common settings: STEP_PERIOD=10, PULSE_HIGH=3.
- Axis 0 aim 5, others 0, from reset → 5 pulses on `stepOut[0]`, each high 3 cycles, `dirOut[0]`=1. `stepperPosition[0]` reads 1..5. `moveDone` is high for one cycle 50 cycles after RUN entry.
- Aim axis 1 = -3, axis 2 = 2 → axis 1 gives 3 pulses with `dirOut[1]`=0, ending at -3 (0xFFFFFFFD). Axis 2 gives 2 pulses, then idles. Move lasts 30 cycles.
- Aim equal to the current position → no pulses, and `moveDone` fires after 10 RUN cycles.
- `aimValid` held high during RUN with a different pose → ignored. The new pose is accepted in the `moveDone` cycle.
- `RST_n` pulsed low mid-pulse → `stepOut`=0 and `stepperPosition`=0 asynchronously, and `aimReady`=1.
- With `STEPPER_SOFT_LIMIT_EN`, POS_MAX=4, aim 7 → exactly 4 pulses, final position 4.
